// File: rtl/cpu_pkg.sv
// Shared RV32I core definitions: data width, canonical NOP, fetch FSM states,
// fetch queue entry layout and the base opcode map used by decode.
package cpu_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [1:0] {
        REQ       = 2'd0,
        WAIT      = 2'd1,
        FLUSHWAIT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Circular buffer of {pc, instr} fetch entries, DEPTH a power of two.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: pushes while full and pops while empty are ignored; flush wins.
module ifq_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   push,
    input  fetch_entry_t           push_dat,
    input  logic                   pop,
    input  logic                   flush,
    output fetch_entry_t           head_dat,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_MASK = AW'(DEPTH - 1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push  = push && (count != CNT_FULL);
    assign do_pop   = pop && (count != '0);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            // Storage is left as-is; only the pointers and occupancy are discarded.
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= (wr_ptr + PTR_ONE) & PTR_MASK;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr + PTR_ONE) & PTR_MASK;
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_ONE;
            end else if (!do_push && do_pop) begin
                count <= count - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/instruction_fetch_queue.sv
// Fetch stage: one outstanding imem request, returned words queued with their PC for decode.
// Latency: request to instrValid is k+1 cycles (same cycle as the response with IFQ_BYPASS_EN).
// Backpressure: decodeReady low fills the queue, then requests stop; redirect flushes everything.
module instruction_fetch_queue
    import cpu_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clock,
    input  logic                   reset_n,
    output logic                   imemReq,
    output logic [XLEN-1:0]        imemAddr,
    input  logic                   imemValid,
    input  logic [XLEN-1:0]        imemData,
    input  logic                   redirectValid,
    input  logic [XLEN-1:0]        redirectPc,
    output logic [XLEN-1:0]        instr,
    output logic [XLEN-1:0]        instrPc,
    output logic                   instrValid,
    input  logic                   decodeReady,
    output logic [$clog2(DEPTH):0] count
);

    localparam int              CW       = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]   CNT_FULL = CW'(DEPTH);
    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);

    fetch_state_t state;
    logic [XLEN-1:0] pc;
    logic            queue_busy;
    logic            resp_take;
    logic            bypass;
    logic            fifo_push;
    logic            fifo_pop;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;

    assign queue_busy = (count != '0);

    // The request is decided in REQ itself so the next fetch follows a response
    // by one cycle; reset_n keeps the strobe low while reset is held.
    assign imemReq  = reset_n && (state == REQ) && !redirectValid && (count != CNT_FULL);
    assign imemAddr = pc;

    assign resp_take = (state == WAIT) && imemValid && !redirectValid;

`ifdef IFQ_BYPASS_EN
    assign bypass = resp_take && !queue_busy && decodeReady;
`else
    assign bypass = 1'b0;
`endif

    assign fifo_push  = resp_take && !bypass;
    assign fifo_pop   = queue_busy && decodeReady;
    assign push_entry = '{pc: pc, instr: imemData};

    assign instrValid = queue_busy || bypass;
    assign instr      = bypass ? imemData : head.instr;
    assign instrPc    = bypass ? pc : head.pc;

    ifq_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .push     (fifo_push),
        .push_dat (push_entry),
        .pop      (fifo_pop),
        .flush    (redirectValid),
        .head_dat (head),
        .count    (count)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= REQ;
            pc    <= RESET_PC;
        end else if (redirectValid) begin
            pc <= word_align(redirectPc);
            // A request still in flight must be absorbed before fetching again.
            if ((state != REQ) && !imemValid) begin
                state <= FLUSHWAIT;
            end else begin
                state <= REQ;
            end
        end else begin
            unique case (state)
                REQ: begin
                    if (imemReq) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (imemValid) begin
                        pc    <= pc + PC_STEP;
                        state <= REQ;
                    end
                end
                FLUSHWAIT: begin
                    if (imemValid) begin
                        state <= REQ;
                    end
                end
                default: state <= REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Scoreboarded bench for instruction_fetch_queue: a memory responder drives imem and
// redirects, a monitor checks every request address and every decode handshake.
`timescale 1ns/1ps
module tb_instruction_fetch_queue;
    import cpu_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic                   clock = 1'b0;
    logic                   reset_n;
    logic                   imemReq;
    logic [31:0]            imemAddr;
    logic                   imemValid;
    logic [31:0]            imemData;
    logic                   redirectValid;
    logic [31:0]            redirectPc;
    logic [31:0]            instr;
    logic [31:0]            instrPc;
    logic                   instrValid;
    logic                   decodeReady;
    logic [$clog2(DEPTH):0] count;

    int checks   = 0;
    int errors   = 0;
    int req_seen = 0;

    logic [31:0]  exp_addr[$];
    fetch_entry_t exp_instr[$];

    bit          wait_arm    = 1'b0;
    bit          resp_arm    = 1'b0;
    bit          now_arm     = 1'b0;
    bit          chk_pending = 1'b0;
    logic [31:0] wait_tgt;
    logic [31:0] resp_tgt;
    logic [31:0] now_tgt;
    logic [31:0] chk_addr;

    instruction_fetch_queue #(
        .DEPTH   (DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .imemReq      (imemReq),
        .imemAddr     (imemAddr),
        .imemValid    (imemValid),
        .imemData     (imemData),
        .redirectValid(redirectValid),
        .redirectPc   (redirectPc),
        .instr        (instr),
        .instrPc      (instrPc),
        .instrValid   (instrValid),
        .decodeReady  (decodeReady),
        .count        (count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a < 32'h0000_0100) return NOP_INSTR;
        return a ^ 32'h5A5A_0000;
    endfunction

    // Fetch order is linear from a redirect target, so both scoreboards restart there.
    task automatic reload(input logic [31:0] tgt);
        logic [31:0] a;
        exp_addr.delete();
        exp_instr.delete();
        a = tgt & 32'hFFFF_FFFC;
        for (int i = 0; i < 40; i++) begin
            exp_addr.push_back(a);
            exp_instr.push_back('{pc: a, instr: mem_word(a)});
            a = a + 32'd4;
        end
    endtask

    // Monitor: every request and every accepted instruction is checked in order.
    initial begin
        logic [31:0]  ea;
        fetch_entry_t ei;
        forever begin
            @(negedge clock);
            if (imemReq === 1'b1) begin
                req_seen++;
                if (exp_addr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL imem_addr_unexpected: got request to 0x%08h, expected none", imemAddr);
                end else begin
                    ea = exp_addr.pop_front();
                    chk("imem_addr", imemAddr, ea);
                end
            end
            if (instrValid === 1'b1 && decodeReady === 1'b1) begin
                if (exp_instr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL instr_unexpected: got pc 0x%08h, expected none", instrPc);
                end else begin
                    ei = exp_instr.pop_front();
                    chk("instr_pc", instrPc, ei.pc);
                    chk("instr", instr, ei.instr);
                end
            end
        end
    end

    // Memory responder (k=1) and the only driver of redirects.
    initial begin
        logic [31:0] addr;
        bit          do_resp;
        imemValid     = 1'b0;
        imemData      = '0;
        redirectValid = 1'b0;
        redirectPc    = '0;
        forever begin
            @(negedge clock);
            if (chk_pending) begin
                chk_pending = 1'b0;
                chk("redir_next_req", 32'(imemReq), 32'd1);
                chk("redir_next_addr", imemAddr, chk_addr);
                chk("redir_count", 32'(count), 32'd0);
            end
            if (now_arm) begin
                now_arm = 1'b0;
                @(posedge clock);
                #1;
                redirectValid = 1'b1;
                redirectPc    = now_tgt;
                @(negedge clock);
                chk("redir_in_req_no_req", 32'(imemReq), 32'd0);
                @(posedge clock);
                reload(now_tgt);
                #1 redirectValid = 1'b0;
                chk_addr    = now_tgt & 32'hFFFF_FFFC;
                chk_pending = 1'b1;
            end else if (imemReq === 1'b1) begin
                addr = imemAddr;
                @(posedge clock);
                #1;
                if (wait_arm) begin
                    wait_arm      = 1'b0;
                    redirectValid = 1'b1;
                    redirectPc    = wait_tgt;
                    @(posedge clock);
                    reload(wait_tgt);
                    #1 redirectValid = 1'b0;
                    @(negedge clock);
                    chk("flushwait_count", 32'(count), 32'd0);
                    chk("flushwait_no_req", 32'(imemReq), 32'd0);
                    @(posedge clock);
                    #1;
                    imemValid = 1'b1;
                    imemData  = mem_word(addr);
                    @(posedge clock);
                    #1 imemValid = 1'b0;
                    chk_addr    = wait_tgt & 32'hFFFF_FFFC;
                    chk_pending = 1'b1;
                end else begin
                    do_resp   = resp_arm;
                    imemValid = 1'b1;
                    imemData  = mem_word(addr);
                    if (do_resp) begin
                        redirectValid = 1'b1;
                        redirectPc    = resp_tgt;
                    end
`ifdef IFQ_BYPASS_EN
                    @(negedge clock);
                    if (!do_resp && decodeReady === 1'b1 && count == 0) begin
                        chk("bypass_valid", 32'(instrValid), 32'd1);
                        chk("bypass_instr", instr, mem_word(addr));
                    end
`endif
                    @(posedge clock);
                    if (do_resp) begin
                        reload(resp_tgt);
                        resp_arm    = 1'b0;
                        chk_addr    = resp_tgt & 32'hFFFF_FFFC;
                        chk_pending = 1'b1;
                    end
                    #1;
                    imemValid     = 1'b0;
                    redirectValid = 1'b0;
                end
            end
        end
    end

    initial begin
        int r0;
        reset_n     = 1'b0;
        decodeReady = 1'b0;
        reload(RESET_PC);
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_imem_req", 32'(imemReq), 32'd0);
        chk("rst_imem_addr", imemAddr, RESET_PC);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_instr_valid", 32'(instrValid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instrPc, 32'd0);

        @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        chk("first_req", 32'(imemReq), 32'd1);
        @(negedge clock);
        chk("resp_cycle_not_valid", 32'(instrValid), 32'd0);
        @(negedge clock);
        chk("first_count", 32'(count), 32'd1);
        chk("first_valid", 32'(instrValid), 32'd1);
        chk("first_instr", instr, 32'h0000_0013);
        chk("first_pc", instrPc, 32'h0000_0000);

        // Stall: queue fills, head holds, requests stop.
        repeat (20) @(negedge clock);
        chk("full_count", 32'(count), 32'd4);
        chk("full_no_req", 32'(imemReq), 32'd0);
        chk("full_valid", 32'(instrValid), 32'd1);
        chk("full_head_pc", instrPc, 32'h0000_0000);
        r0 = req_seen;

        @(posedge clock);
        #1 decodeReady = 1'b1;
        @(posedge clock);
        #1 decodeReady = 1'b0;
        repeat (10) @(negedge clock);
        chk("refill_count", 32'(count), 32'd4);
        chk("refill_one_req", 32'(req_seen - r0), 32'd1);
        chk("refill_head_pc", instrPc, 32'h0000_0004);

        @(posedge clock);
        #1 decodeReady = 1'b1;
        repeat (30) @(posedge clock);
        wait_tgt = 32'h0000_1003;
        wait_arm = 1'b1;
        repeat (15) @(posedge clock);
        resp_tgt = 32'h0000_2006;
        resp_arm = 1'b1;
        repeat (15) @(posedge clock);
        wait_tgt = 32'hFFFF_FFF8;
        wait_arm = 1'b1;
        repeat (20) @(posedge clock);
        #1 decodeReady = 1'b0;
        repeat (15) @(negedge clock);
        chk("wrap_full_count", 32'(count), 32'd4);
        chk("wrap_full_no_req", 32'(imemReq), 32'd0);

        now_tgt = 32'h0000_3000;
        now_arm = 1'b1;
        repeat (15) @(negedge clock);
        chk("after_req_redir_count", 32'(count), 32'd4);
        chk("after_req_redir_pc", instrPc, 32'h0000_3000);
        chk("after_req_redir_instr", instr, 32'h5A5A_3000);
        chk("redirects_consumed", {29'd0, wait_arm, resp_arm, now_arm}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
